// File: rtl/key_debounce_pulse.sv
// Per-channel push-button conditioner: two-flop synchronizer, stable-time
// qualification FSM, and registered level / press / release outputs.
module key_debounce_pulse #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  logic [NUM_KEYS-1:0] sync_meta;
  logic [NUM_KEYS-1:0] sync_level;

  // Two-flop synchronizer; inverts so a pressed key reads as 1
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_meta  <= '0;
      sync_level <= '0;
    end else begin
      sync_meta  <= ~KEY;
      sync_level <= sync_meta;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             level_q;
    logic             level_next;
    logic             press_q;
    logic             press_next;
    logic             release_q;
    logic             release_next;
    logic             s;

    assign s              = sync_level[i];
    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;

    // State, counter and output registers; reset overrides any qualification
    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        state     <= RELEASED;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_next;
        cnt       <= cnt_next;
        level_q   <= level_next;
        press_q   <= press_next;
        release_q <= release_next;
      end
    end

    // Next-state logic: the counter restarts on every state entry and a
    // transition qualifies only after the sampled level holds for the full window
    always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      level_next   = level_q;
      press_next   = 1'b0;
      release_next = 1'b0;
      case (state)
        RELEASED: begin
          if (s) begin
            state_next = WAIT_PRESS;
            cnt_next   = '0;
          end
        end
        WAIT_PRESS: begin
          if (!s) begin
            state_next = RELEASED;
            cnt_next   = '0;
          end else if (cnt == CNT_MAX) begin
            state_next = PRESSED;
            cnt_next   = '0;
            level_next = 1'b1;
            press_next = 1'b1;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!s) begin
            state_next = WAIT_RELEASE;
            cnt_next   = '0;
          end
        end
        WAIT_RELEASE: begin
          if (s) begin
            state_next = PRESSED;
            cnt_next   = '0;
          end else if (cnt == CNT_MAX) begin
            state_next   = RELEASED;
            cnt_next     = '0;
            level_next   = 1'b0;
            release_next = 1'b1;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_next = RELEASED;
          cnt_next   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Self-checking bench for key_debounce_pulse with a short debounce window.
module tb_key_debounce_pulse;

  localparam int NK = 4;
  localparam int DB = 4;

  logic          clk;
  logic          reset;
  logic [NK-1:0] KEY;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  int errors = 0;
  int checks = 0;

  key_debounce_pulse #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .KEY        (KEY),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the sampled level is the inverted key from two edges
  // ago; a channel flips once the sample has disagreed with its debounced
  // level for DB+1 consecutive edges.
  logic [NK-1:0] hist0, hist1;
  logic [NK-1:0] m_level, m_press, m_rel;
  int            run [NK];

  task automatic model_edge(input logic r, input logic [NK-1:0] k);
    logic s;
    if (r) begin
      hist0 = '0; hist1 = '0; m_level = '0; m_press = '0; m_rel = '0;
      for (int i = 0; i < NK; i++) run[i] = 0;
    end else begin
      for (int i = 0; i < NK; i++) begin
        s = hist1[i];
        m_press[i] = 1'b0;
        m_rel[i]   = 1'b0;
        if (s != m_level[i]) begin
          run[i]++;
          if (run[i] == DB + 1) begin
            m_level[i] = s;
            m_press[i] = s;
            m_rel[i]   = ~s;
            run[i]     = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      hist1 = hist0;
      hist0 = ~k;
    end
  endtask

  task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model, compare just after the edge
  task automatic step(input logic r, input logic [NK-1:0] k);
    reset = r;
    KEY   = k;
    @(posedge clk);
    model_edge(r, k);
    #1;
    chk("model_level",   key_level,   m_level);
    chk("model_press",   key_press,   m_press);
    chk("model_release", key_release, m_rel);
    chk("press_release_overlap", key_press & key_release, '0);
  endtask

  task automatic expect_out(input string name, input logic [NK-1:0] lvl,
                            input logic [NK-1:0] prs, input logic [NK-1:0] rel);
    chk({name, "_level"},   key_level,   lvl);
    chk({name, "_press"},   key_press,   prs);
    chk({name, "_release"}, key_release, rel);
  endtask

  typedef struct {
    logic          rst;
    logic [NK-1:0] key;
    logic [NK-1:0] lvl;
    logic [NK-1:0] prs;
    logic [NK-1:0] rel;
  } vec_t;

  vec_t tbl [30];
  int   hold [NK];
  logic [NK-1:0] kv;

  initial begin
    // Reset for 10 cycles with keys idle, then hold KEY[0] low for 20 edges
    for (int i = 0; i < 30; i++) begin
      if (i < 10) begin
        tbl[i] = '{rst: 1'b1, key: 4'hF, lvl: 4'h0, prs: 4'h0, rel: 4'h0};
      end else begin
        tbl[i].rst = 1'b0;
        tbl[i].key = 4'hE;
        tbl[i].lvl = (i - 9 >= 7) ? 4'h1 : 4'h0;
        tbl[i].prs = (i - 9 == 7) ? 4'h1 : 4'h0;
        tbl[i].rel = 4'h0;
      end
    end

    reset = 1'b1;
    KEY   = '1;
    hist0 = '0; hist1 = '0; m_level = '0; m_press = '0; m_rel = '0;
    for (int i = 0; i < NK; i++) run[i] = 0;

    for (int i = 0; i < 30; i++) begin
      step(tbl[i].rst, tbl[i].key);
      expect_out($sformatf("tbl%0d", i), tbl[i].lvl, tbl[i].prs, tbl[i].rel);
    end

    // Glitches of 3 and 4 cycles on KEY[1] while channel 0 stays pressed
    for (int g = 3; g <= 4; g++) begin
      for (int n = 0; n < g; n++) begin
        step(1'b0, 4'b1100);
        expect_out($sformatf("glitch%0d_in", g), 4'h1, 4'h0, 4'h0);
      end
      for (int n = 0; n < 10; n++) begin
        step(1'b0, 4'b1110);
        expect_out($sformatf("glitch%0d_after", g), 4'h1, 4'h0, 4'h0);
      end
    end

    // Release channel 0: pulse on the 7th edge after release
    for (int n = 1; n <= 10; n++) begin
      step(1'b0, 4'hF);
      expect_out($sformatf("release_e%0d", n), (n >= 7) ? 4'h0 : 4'h1,
                 4'h0, (n == 7) ? 4'h1 : 4'h0);
    end

    // Reset while channel 0 is waiting to qualify, key kept low
    for (int n = 0; n < 4; n++) step(1'b0, 4'hE);
    step(1'b1, 4'hE);
    expect_out("rst_wait", 4'h0, 4'h0, 4'h0);
    for (int n = 1; n <= 9; n++) begin
      step(1'b0, 4'hE);
      expect_out($sformatf("requal1_e%0d", n), (n >= 7) ? 4'h1 : 4'h0,
                 (n == 7) ? 4'h1 : 4'h0, 4'h0);
    end

    // Reset while channel 0 is pressed, key still low
    step(1'b1, 4'hE);
    expect_out("rst_pressed", 4'h0, 4'h0, 4'h0);
    for (int n = 1; n <= 8; n++) begin
      step(1'b0, 4'hE);
      expect_out($sformatf("requal2_e%0d", n), (n >= 7) ? 4'h1 : 4'h0,
                 (n == 7) ? 4'h1 : 4'h0, 4'h0);
    end
    for (int n = 0; n < 10; n++) step(1'b0, 4'hF);
    expect_out("idle_again", 4'h0, 4'h0, 4'h0);

    // Two channels pressed on the same edge
    for (int n = 1; n <= 9; n++) begin
      step(1'b0, 4'b0011);
      chk($sformatf("dual_press_e%0d", n), key_press, (n == 7) ? 4'b1100 : 4'b0000);
    end
    for (int n = 0; n < 10; n++) step(1'b0, 4'hF);

    // Random bouncing keys with occasional reset, checked against the model
    for (int i = 0; i < NK; i++) hold[i] = 0;
    kv = '1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NK; i++) begin
        if (hold[i] == 0) begin
          kv[i]   = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 12);
        end
        hold[i]--;
      end
      step(($urandom_range(0, 199) == 0), kv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
